// File: rtl/mem_pkg.sv
// Shared definitions for the multi-port arbitrated memory: latency bounds,
// FSM state encoding and a width helper that never returns zero.
package mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel
// and wraps; the pointer only moves when a grant is actually taken.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    win_idx = ptr_q;
    idx     = ptr_q;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_arb_nport.sv
// NUM_CH-channel valid/ready front end onto one single-port array, with
// zero-fill after reset, 1- or 2-cycle read latency and range checking.
module mem_arb_nport
  import mem_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = clog2_min1(DEPTH),
  parameter int NUM_CH     = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_wr_rd,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*WIDTH-1:0]      ch_wdata,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [WIDTH-1:0]             rdata,
  output logic                         err,
  output logic                         init_done
);

  localparam int PW = clog2_min1(NUM_CH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;

  logic [NUM_CH-1:0]     gnt;
  logic [PW-1:0]         rr_ptr_unused;
  logic                  acc, acc_wr, acc_oor;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [WIDTH-1:0]      acc_wdata;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  logic [NUM_CH-1:0]     rvalid_p1_q, rvalid_p1_d;
  logic [WIDTH-1:0]      rdata_p1_q, rdata_p1_d;
  logic                  err_p1_q, err_p1_d;

  rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (ch_valid & {NUM_CH{state_q == ST_RUN}}),
    .advance(acc),
    .gnt    (gnt),
    .ptr    (rr_ptr_unused)
  );

  assign ch_ready = gnt;
  assign acc      = |gnt;
  assign acc_oor  = {1'b0, acc_addr} >= (ADDR_WIDTH + 1)'(DEPTH);

  always_comb begin
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) begin
        acc_wr    = ch_wr_rd[k];
        acc_addr  = ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        acc_wdata = ch_wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Single write port shared by the zero-fill walk and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_cnt_q;
    mem_wdata = '0;
    if (state_q == ST_INIT) begin
      mem_we = rst;
    end else if (acc && acc_wr && !acc_oor) begin
      mem_we    = 1'b1;
      mem_waddr = acc_addr;
      mem_wdata = acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // p1: response captured on the accepting edge; rdata holds between reads.
  always_comb begin
    rvalid_p1_d = '0;
    rdata_p1_d  = rdata_p1_q;
    err_p1_d    = acc && acc_oor;
    if (acc && !acc_wr) begin
      rvalid_p1_d = gnt;
      rdata_p1_d  = acc_oor ? '0 : mem_q[acc_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_p1_q <= '0;
      rdata_p1_q  <= '0;
      err_p1_q    <= 1'b0;
    end else begin
      rvalid_p1_q <= rvalid_p1_d;
      rdata_p1_q  <= rdata_p1_d;
      err_p1_q    <= err_p1_d;
    end
  end

  generate
    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
      // p2: extra output register stage for the longer latency option.
      logic [NUM_CH-1:0] rvalid_p2_q;
      logic [WIDTH-1:0]  rdata_p2_q;
      logic              err_p2_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rvalid_p2_q <= '0;
          rdata_p2_q  <= '0;
          err_p2_q    <= 1'b0;
        end else begin
          rvalid_p2_q <= rvalid_p1_q;
          rdata_p2_q  <= rdata_p1_q;
          err_p2_q    <= err_p1_q;
        end
      end

      assign ch_rvalid = rvalid_p2_q;
      assign rdata     = rdata_p2_q;
      assign err       = err_p2_q;
    end else begin : g_lat1
      assign ch_rvalid = rvalid_p1_q;
      assign rdata     = rdata_p1_q;
      assign err       = err_p1_q;
    end
  endgenerate

  assign init_done = init_done_q;

endmodule
